// File: rtl/fifo_pkg.sv
// Shared helpers for the parametrised FIFO: pointer/count width functions
// and the reset values of the registered error pulses.
package fifo_pkg;

  // Width of a read/write pointer addressing DEPTH entries.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Width of an occupancy counter that must also represent DEPTH itself.
  function automatic int count_width(input int depth);
    return ptr_width(depth) + 1;
  endfunction

  localparam logic RST_OVERFLOW  = 1'b0;
  localparam logic RST_UNDERFLOW = 1'b0;

endpackage

// File: rtl/fifo_mem.sv
// Register file for the FIFO: one synchronous write port, one asynchronous
// read port. Contents are deliberately not reset.
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Store the incoming word at the write address when enabled.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/param_fifo.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty
// flags and overflow/underflow pulses. Define PARAM_FIFO_FWFT_EN for
// first-word-fall-through output; otherwise dout is a registered read.
module param_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       din,
  input  logic                   wr_en,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = ptr_width(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, underflow_q;
  logic             full_w, empty_w;
  logic             rd_ok, wr_ok;
  logic [WIDTH-1:0] rd_data;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == CW'(DEPTH));

  // A read needs a stored word; a write into a full FIFO is fine if a read
  // frees the oldest slot on the same edge.
  assign rd_ok = rd_en && !empty_w;
  assign wr_ok = wr_en && (!full_w || rd_en);

  // Advance pointers and occupancy for the accepted operations only.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State register; reset discards all stored words and suppresses pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= RST_OVERFLOW;
      underflow_q <= RST_UNDERFLOW;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= wr_en && !wr_ok;
      underflow_q <= rd_en && !rd_ok;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_ok && !rst),
    .waddr_i (wr_ptr_q),
    .wdata_i (din),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

`ifdef PARAM_FIFO_FWFT_EN
  // Head of the queue is always visible; blank when nothing is stored.
  assign dout = empty_w ? '0 : rd_data;
`else
  logic [WIDTH-1:0] dout_q;

  // Capture the head word on an accepted read; hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
    end else if (rd_ok) begin
      dout_q <= rd_data;
    end
  end

  assign dout = dout_q;
`endif

  assign count        = count_q;
  assign full         = full_w;
  assign empty        = empty_w;
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench for param_fifo using a queue scoreboard; handles both
// the registered-read and the PARAM_FIFO_FWFT_EN output behaviour.
module tb_param_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] din;
  logic             wr_en, rd_en;
  logic [WIDTH-1:0] dout;
  logic             full, empty, almost_full, almost_empty;
  logic [CW-1:0]    count;
  logic             overflow, underflow;

  always #5 clk = ~clk;

  param_fifo #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .dout         (dout),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [WIDTH-1:0] q[$];
  int               count_m = 0;
  logic [WIDTH-1:0] dout_m  = '0;

  task automatic check(input string tag, input longint obs, input longint exp);
    total_cnt++;
    if (obs == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Compare every output against the model after an edge.
  task automatic check_outputs(input bit exp_ovf, input bit exp_udf);
    check("count", count, count_m);
    check("full", full, count_m == DEPTH);
    check("empty", empty, count_m == 0);
    check("almost_full", almost_full, count_m >= AF);
    check("almost_empty", almost_empty, count_m <= AE);
    check("overflow", overflow, exp_ovf);
    check("underflow", underflow, exp_udf);
`ifdef PARAM_FIFO_FWFT_EN
    check("dout", dout, (q.size() != 0) ? q[0] : '0);
`else
    check("dout", dout, dout_m);
`endif
  endtask

  // One clock of stimulus; inputs are driven 1 time unit after the edge.
  task automatic cycle(input bit w, input bit r, input logic [WIDTH-1:0] d);
    bit rd_ok, wr_ok;
    wr_en = w;
    rd_en = r;
    din   = d;
    rd_ok = r && (count_m != 0);
    wr_ok = w && ((count_m != DEPTH) || r);
    @(posedge clk);
    #1;
    if (rd_ok) dout_m = q.pop_front();
    if (wr_ok) q.push_back(d);
    count_m = count_m + int'(wr_ok) - int'(rd_ok);
    check_outputs(w && !wr_ok, r && !rd_ok);
    $display("t=%0t wr=%0d rd=%0d din=%0d -> count=%0d dout=%0d ovf=%0d udf=%0d",
             $time, w, r, d, count, dout, overflow, underflow);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  // Reset for one edge, optionally with a write request held high.
  task automatic do_reset(input bit w);
    rst   = 1'b1;
    wr_en = w;
    rd_en = 1'b0;
    din   = 8'hAA;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    wr_en = 1'b0;
    q.delete();
    count_m = 0;
    dout_m  = '0;
    check_outputs(1'b0, 1'b0);
    check("rst_dout", dout, 0);
    $display("t=%0t reset (wr_en=%0d) -> count=%0d empty=%0d dout=%0d",
             $time, w, count, empty, dout);
  endtask

  initial begin
    rst   = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset(1'b0);

    // Basic ordering and latency.
    cycle(1, 0, 8'd10);
    cycle(0, 0, 8'd0);
    cycle(1, 0, 8'd7);
    cycle(0, 1, 8'd0);
    cycle(0, 1, 8'd0);
    cycle(0, 0, 8'd0);

    // Fill, overflow, drain with wrapped pointers.
    for (int i = 0; i < DEPTH; i++) cycle(1, 0, WIDTH'(i));
    cycle(1, 0, 8'd16);
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 8'd0);
    cycle(0, 0, 8'd0);

    // Full with simultaneous read and write.
    for (int i = 0; i < DEPTH; i++) cycle(1, 0, WIDTH'(i + 32));
    cycle(1, 1, 8'd99);
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 8'd0);
    cycle(0, 1, 8'd0);
    cycle(0, 0, 8'd0);

    // Empty with simultaneous read and write.
    cycle(1, 1, 8'd5);
    cycle(0, 1, 8'd0);
    cycle(0, 0, 8'd0);

    // Reset during continuous writes at count 9.
    for (int i = 0; i < 9; i++) cycle(1, 0, WIDTH'(i + 100));
    do_reset(1'b1);
    cycle(0, 0, 8'd0);

    // Mixed random traffic.
    for (int i = 0; i < 150; i++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), WIDTH'($urandom));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
